// File: rtl/ex_ma_pipe_reg.sv
// EX->MA pipeline register with a valid/ready handshake, an optional 2-entry skid buffer,
// synchronous flush, bubble-gated write enables and a saturating stall-cycle counter.
module ex_ma_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SKID       = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] AddrD_in,
  input  logic                  RegWEn_in,
  input  logic                  MemRW_in,
  input  logic [1:0]            WBSel_in,
  input  logic [2:0]            funct3_in,
  input  logic [XLEN-1:0]       ALU_Result_in,
  input  logic [XLEN-1:0]       DataB_in,
  input  logic [XLEN-1:0]       pcPlus4_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] AddrD_out,
  output logic                  RegWEn_out,
  output logic                  MemRW_out,
  output logic [1:0]            WBSel_out,
  output logic [2:0]            funct3_out,
  output logic [XLEN-1:0]       ALU_Result_out,
  output logic [XLEN-1:0]       DataB_out,
  output logic [XLEN-1:0]       pcPlus4_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr_d;
    logic                  reg_wen;
    logic                  mem_rw;
    logic [1:0]            wb_sel;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       data_b;
    logic [XLEN-1:0]       pc_plus4;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t     state_q, state_d;
  payload_t   in_pl, m_q, s_pl;
  logic       load_m, load_s, m_from_s;
  logic       accept, emit;
  logic [CNT_W-1:0] cnt_q;

  assign in_pl = '{addr_d: AddrD_in, reg_wen: RegWEn_in, mem_rw: MemRW_in, wb_sel: WBSel_in,
                   funct3: funct3_in, alu_result: ALU_Result_in, data_b: DataB_in,
                   pc_plus4: pcPlus4_in};

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // flush wins over everything: no loads, straight back to EMPTY
  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          load_m  = 1'b1;
          state_d = ONE;
        end
        ONE: begin
          if (emit && accept) begin
            load_m = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end else if (accept && SKID != 0) begin
            load_s  = 1'b1;
            state_d = FULL;
          end
        end
        FULL: if (emit) begin
          m_from_s = 1'b1;
          state_d  = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic     rdy_q;
      payload_t s_q;
      // in_ready comes straight from a flop so EX never sees a path through out_ready
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_q <= 1'b1;
        else          rdy_q <= (state_d != FULL);
      end
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    s_q <= '0;
        else if (load_s) s_q <= in_pl;
      end
      assign in_ready = rdy_q;
      assign s_pl     = s_q;
    end else begin : g_noskid
      assign in_ready = (state_q == EMPTY) | out_ready;
      assign s_pl     = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      m_q <= '0;
    else if (load_m)   m_q <= in_pl;
    else if (m_from_s) m_q <= s_pl;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               cnt_q <= '0;
    else if (out_valid && !out_ready && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign AddrD_out      = m_q.addr_d;
  assign RegWEn_out     = m_q.reg_wen & out_valid;
  assign MemRW_out      = m_q.mem_rw  & out_valid;
  assign WBSel_out      = m_q.wb_sel;
  assign funct3_out     = m_q.funct3;
  assign ALU_Result_out = m_q.alu_result;
  assign DataB_out      = m_q.data_b;
  assign pcPlus4_out    = m_q.pc_plus4;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_ex_ma_pipe_reg.sv
// Directed bench for ex_ma_pipe_reg: a SKID=1/CNT_W=4 instance plus a SKID=0 instance on shared inputs.
module tb_ex_ma_pipe_reg;
  localparam int XLEN = 32, RW = 5, CW = 4;

  logic            clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic            in_valid = 1'b0, out_ready = 1'b0;
  logic [RW-1:0]   AddrD_in = '0;
  logic            RegWEn_in = 1'b0, MemRW_in = 1'b0;
  logic [1:0]      WBSel_in = '0;
  logic [2:0]      funct3_in = '0;
  logic [XLEN-1:0] ALU_Result_in = '0, DataB_in = '0, pcPlus4_in = '0;

  logic            in_ready, out_valid, RegWEn_out, MemRW_out;
  logic [RW-1:0]   AddrD_out;
  logic [1:0]      WBSel_out;
  logic [2:0]      funct3_out;
  logic [XLEN-1:0] ALU_Result_out, DataB_out, pcPlus4_out;
  logic [CW-1:0]   stall_cnt;

  logic            in_ready0, out_valid0, RegWEn_out0, MemRW_out0;
  logic [RW-1:0]   AddrD_out0;
  logic [1:0]      WBSel_out0;
  logic [2:0]      funct3_out0;
  logic [XLEN-1:0] ALU_Result_out0, DataB_out0, pcPlus4_out0;
  logic [15:0]     stall_cnt0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ex_ma_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RW), .SKID(1), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .AddrD_in(AddrD_in), .RegWEn_in(RegWEn_in), .MemRW_in(MemRW_in), .WBSel_in(WBSel_in),
    .funct3_in(funct3_in), .ALU_Result_in(ALU_Result_in), .DataB_in(DataB_in),
    .pcPlus4_in(pcPlus4_in), .out_valid(out_valid), .out_ready(out_ready),
    .AddrD_out(AddrD_out), .RegWEn_out(RegWEn_out), .MemRW_out(MemRW_out),
    .WBSel_out(WBSel_out), .funct3_out(funct3_out), .ALU_Result_out(ALU_Result_out),
    .DataB_out(DataB_out), .pcPlus4_out(pcPlus4_out), .stall_cnt(stall_cnt));

  ex_ma_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RW), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .AddrD_in(AddrD_in), .RegWEn_in(RegWEn_in), .MemRW_in(MemRW_in), .WBSel_in(WBSel_in),
    .funct3_in(funct3_in), .ALU_Result_in(ALU_Result_in), .DataB_in(DataB_in),
    .pcPlus4_in(pcPlus4_in), .out_valid(out_valid0), .out_ready(out_ready),
    .AddrD_out(AddrD_out0), .RegWEn_out(RegWEn_out0), .MemRW_out(MemRW_out0),
    .WBSel_out(WBSel_out0), .funct3_out(funct3_out0), .ALU_Result_out(ALU_Result_out0),
    .DataB_out(DataB_out0), .pcPlus4_out(pcPlus4_out0), .stall_cnt(stall_cnt0));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] a, input logic rw, input logic mw,
                       input logic [XLEN-1:0] alu);
    in_valid = v; AddrD_in = a; RegWEn_in = rw; MemRW_in = mw; ALU_Result_in = alu;
    DataB_in = alu ^ 32'hFFFF_0000; pcPlus4_in = alu + 4; WBSel_in = 2'd1; funct3_in = 3'd2;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    flush = 1'b0; out_ready = 1'b0; reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== '0 || ALU_Result_out !== '0 ||
        AddrD_out !== '0 || RegWEn_out !== 1'b0 || MemRW_out !== 1'b0 || pcPlus4_out !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b stall=%0d alu=%h addr=%0d rw=%b mw=%b pc4=%h, want 0 1 0 0 0 0 0 0",
               out_valid, in_ready, stall_cnt, ALU_Result_out, AddrD_out, RegWEn_out, MemRW_out, pcPlus4_out);
    end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 1'b0, 32'h1000);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b1 || ALU_Result_out !== 32'h1000 || AddrD_out !== 5'd5 ||
        RegWEn_out !== 1'b1 || pcPlus4_out !== 32'h1004 || DataB_out !== 32'hFFFF_1000) begin
      errors++;
      $display("FAIL basic_latency: vld=%b alu=%h addr=%0d rw=%b pc4=%h db=%h, want 1 1000 5 1 1004 ffff1000",
               out_valid, ALU_Result_out, AddrD_out, RegWEn_out, pcPlus4_out, DataB_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || RegWEn_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: vld=%b rw=%b, want 0 0", out_valid, RegWEn_out);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, RW'(i), 1'b1, 1'b0, 32'(100 + i));
      tick();
      checks++;
      if (out_valid !== 1'b1 || ALU_Result_out !== 32'(100 + i) || AddrD_out !== RW'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: vld=%b alu=%0d addr=%0d rdy=%b, want 1 %0d %0d 1",
                 i, out_valid, ALU_Result_out, AddrD_out, in_ready, 100 + i, i);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 5'd1, 1'b1, 1'b0, 32'hA);
    tick();
    checks++;
    if (out_valid !== 1'b1 || ALU_Result_out !== 32'hA || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_a: vld=%b alu=%h rdy=%b, want 1 a 1", out_valid, ALU_Result_out, in_ready);
    end
    drive(1'b1, 5'd2, 1'b1, 1'b0, 32'hB);
    tick();
    checks++;
    if (in_ready !== 1'b0 || ALU_Result_out !== 32'hA || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_full: rdy=%b alu=%h vld=%b, want 0 a 1", in_ready, ALU_Result_out, out_valid);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || ALU_Result_out !== 32'hB || AddrD_out !== 5'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_b: vld=%b alu=%h addr=%0d rdy=%b, want 1 b 2 1", out_valid, ALU_Result_out, AddrD_out, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_drain: vld=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 32'h30);
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b1, 32'h40);
    tick();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 32'h70);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (out_valid !== 1'b0 || RegWEn_out !== 1'b0 || MemRW_out !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: vld=%b rw=%b mw=%b rdy=%b, want 0 0 0 1", out_valid, RegWEn_out, MemRW_out, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_residue[%0d]: vld=%b alu=%h, want vld 0", i, out_valid, ALU_Result_out);
      end
    end
  endtask

  task automatic test_stall_cnt();
    do_reset();
    drive(1'b1, 5'd9, 1'b0, 1'b0, 32'h90);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_start: got %0d, want 0", stall_cnt);
    end
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 5) begin
        checks++;
        if (stall_cnt !== 4'd5) begin
          errors++;
          $display("FAIL stall_5: got %0d, want 5", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat: got %0d, want 15", stall_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_after_flush: cnt=%0d vld=%b, want 15 0", stall_cnt, out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h600);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (MemRW_out !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: mw=%b vld=%b, want 1 1", MemRW_out, out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (MemRW_out !== 1'b0 || out_valid !== 1'b0 || RegWEn_out !== 1'b0 || ALU_Result_out !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_async: mw=%b vld=%b rw=%b alu=%h rdy=%b, want 0 0 0 0 1",
               MemRW_out, out_valid, RegWEn_out, ALU_Result_out, in_ready);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_noskid();
    do_reset();
    drive(1'b1, 5'd11, 1'b1, 1'b0, 32'hC0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    checks++;
    if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || ALU_Result_out0 !== 32'hC0) begin
      errors++;
      $display("FAIL noskid_stall: vld=%b rdy=%b alu=%h, want 1 0 c0", out_valid0, in_ready0, ALU_Result_out0);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL noskid_comb_ready: rdy=%b, want 1", in_ready0);
    end
    drive(1'b1, 5'd12, 1'b1, 1'b0, 32'hD0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (out_valid0 !== 1'b1 || ALU_Result_out0 !== 32'hD0 || AddrD_out0 !== 5'd12) begin
      errors++;
      $display("FAIL noskid_pass: vld=%b alu=%h addr=%0d, want 1 d0 12", out_valid0, ALU_Result_out0, AddrD_out0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_back_to_back();
    test_flush();
    test_stall_cnt();
    test_async_reset();
    test_noskid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
